// File: rtl/miner_result_pkg.sv
// Shared types and helpers for the miner result path.
package miner_result_pkg;

    localparam int unsigned NONCE_W = 32;

    typedef logic [NONCE_W-1:0] nonce_t;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/lowest_set_encoder.sv
// Combinational priority encoder: index of the lowest set bit plus any/multi flags.
module lowest_set_encoder
    import miner_result_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = idx_width(N)
) (
    input  logic [N-1:0] bits_i,
    output logic [W-1:0] idx_o,
    output logic         any_o,
    output logic         multi_o
);

    logic seen;

    always_comb begin
        idx_o   = '0;
        any_o   = 1'b0;
        multi_o = 1'b0;
        seen    = 1'b0;
        // Descending scan so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (bits_i[i]) begin
                idx_o = W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (bits_i[i]) begin
                if (seen) begin
                    multi_o = 1'b1;
                end
                seen  = 1'b1;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nonce_result_collector.sv
// Collects lockstep core hits, rebuilds the winning nonce and offers it over valid/ready.
// Optional hit_count output enabled by NONCE_RESULT_HIT_COUNT_EN.
module nonce_result_collector #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned NONCE_W   = miner_result_pkg::NONCE_W
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic [NUM_CORES-1:0]                                   core_valid,
    input  logic [NUM_CORES-1:0]                                   core_newblock,
    input  logic [NUM_CORES-1:0]                                   core_success,
    input  logic [NUM_CORES*miner_result_pkg::idx_width(NUM_CORES)-1:0] core_prefix,
    output logic                                                   result_valid,
    input  logic                                                   result_ready,
    output logic [NONCE_W-1:0]                                     result_nonce,
    output logic                                                   result_multi,
    output logic                                                   overflow,
    output logic                                                   exhausted,
    output logic                                                   lockstep_err
`ifdef NONCE_RESULT_HIT_COUNT_EN
   ,output logic [15:0]                                            hit_count
`endif
);

    localparam int unsigned IDX_W = miner_result_pkg::idx_width(NUM_CORES);
    localparam int unsigned CNT_W = NONCE_W - IDX_W;

    logic                 iter, nb, hit, xfer;
    logic [CNT_W-1:0]     iter_q, iter_d, used_cnt;
    logic                 valid_q, valid_d, multi_q, multi_d;
    logic                 ovf_q, ovf_d, exh_q, exh_d, lock_q, lock_d;
    logic [NONCE_W-1:0]   nonce_q, nonce_d;
    logic [NUM_CORES-1:0] succ;
    logic [IDX_W-1:0]     win_idx, win_prefix;
    logic                 succ_any, succ_multi;

    assign iter     = core_valid[0];
    assign nb       = iter & core_newblock[0];
    assign used_cnt = nb ? '0 : iter_q;
    assign succ     = iter ? core_success : '0;
    assign hit      = iter & succ_any;
    assign xfer     = valid_q & result_ready;

    lowest_set_encoder #(
        .N (NUM_CORES),
        .W (IDX_W)
    ) u_enc (
        .bits_i  (succ),
        .idx_o   (win_idx),
        .any_o   (succ_any),
        .multi_o (succ_multi)
    );

    always_comb begin
        win_prefix = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_prefix = core_prefix[i*IDX_W +: IDX_W];
            end
        end
    end

    always_comb begin
        iter_d = iter_q;
        exh_d  = 1'b0;
        lock_d = lock_q;
        if (iter) begin
            iter_d = used_cnt + CNT_W'(1);
            exh_d  = &used_cnt;
        end
        if ((|core_valid) && !(&core_valid)) begin
            lock_d = 1'b1;
        end
        if (iter && (|core_newblock) && !(&core_newblock)) begin
            lock_d = 1'b1;
        end
    end

    // Order matters: transfer and newblock flush empty the slot before the hit decides.
    always_comb begin
        valid_d = valid_q;
        nonce_d = nonce_q;
        multi_d = multi_q;
        ovf_d   = ovf_q;
        if (xfer) begin
            valid_d = 1'b0;
        end
        if (nb) begin
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end
        if (hit) begin
            if (valid_d) begin
                ovf_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                nonce_d = {used_cnt, win_prefix};
                multi_d = succ_multi;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iter_q  <= '0;
            valid_q <= 1'b0;
            nonce_q <= '0;
            multi_q <= 1'b0;
            ovf_q   <= 1'b0;
            exh_q   <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            iter_q  <= iter_d;
            valid_q <= valid_d;
            nonce_q <= nonce_d;
            multi_q <= multi_d;
            ovf_q   <= ovf_d;
            exh_q   <= exh_d;
            lock_q  <= lock_d;
        end
    end

    assign result_valid = valid_q;
    assign result_nonce = nonce_q;
    assign result_multi = multi_q;
    assign overflow     = ovf_q;
    assign exhausted    = exh_q;
    assign lockstep_err = lock_q;

`ifdef NONCE_RESULT_HIT_COUNT_EN
    logic [15:0] hc_q, hc_d;

    always_comb begin
        hc_d = hc_q;
        if (nb) begin
            hc_d = '0;
        end
        if (hit && (hc_d != 16'hFFFF)) begin
            hc_d = hc_d + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hc_q <= '0;
        end else begin
            hc_q <= hc_d;
        end
    end

    assign hit_count = hc_q;
`endif

endmodule

// File: doc/nonce_result_collector.md
Name: nonce_result_collector

Overview:
- Reader side of the per-core processor-results interface.
- Collects success/nonce_prefix/valid/newblock from NUM_CORES lockstep hashing cores.
- Reconstructs the full 32-bit winning nonce by iteration counting.
- Presents one result at a time to the host-side controller over a valid/ready handshake.

Parameters:
- NUM_CORES, 4: number of lattice cores; power of two, >=2.
- NONCE_W, 32: width of the reconstructed nonce.
- IDX_W, $clog2(NUM_CORES): width of the per-core nonce prefix (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- core_valid  in  NUM_CORES  per-core hash-valid strobe (validOut).
- core_newblock  in  NUM_CORES  per-core first-iteration-of-new-block flag (newBlockOut).
- core_success  in  NUM_CORES  per-core difficulty-met flag (success).
- core_prefix  in  NUM_CORES*IDX_W  per-core nonce_prefix; core i occupies bits [i*IDX_W +: IDX_W].
- result_valid  out  1  result register holds an unconsumed nonce.
- result_ready  in  1  consumer accepts the result.
- result_nonce  out  NONCE_W  winning nonce {iter_count, prefix}.
- result_multi  out  1  more than one core succeeded in the result's iteration.
- overflow  out  1  sticky; a hit was dropped.
- exhausted  out  1  one-cycle pulse; nonce space for this block wrapped.
- lockstep_err  out  1  sticky; core_valid or core_newblock not uniform across cores.

Behaviour:
- Reset (rst=0, async): result_valid=0, result_nonce=0, result_multi=0, overflow=0, exhausted=0, lockstep_err=0, iter_count=0. All other outputs are registered; none is combinational from inputs.
- Iteration: any cycle with core_valid[0]=1. Other cores are sampled only in iteration cycles.
- Lockstep check: if core_valid is neither all-0 nor all-1, set lockstep_err. In iteration cycles, if core_newblock is not uniform, set lockstep_err. Only rst clears lockstep_err.
- Counter:
  - iter_count is NONCE_W-IDX_W bits.
  - Iteration with core_newblock[0]=1: that iteration uses count 0; next count=1.
  - Otherwise the iteration uses the current count; next count = count+1.
  - Iteration using count all-ones: counter wraps to 0; exhausted pulses high in the following cycle.
- Hit: iteration cycle with any core_success=1.
  - Winner = lowest core index with success, via priority encoder.
  - Candidate nonce = {used count, core_prefix of winner}.
  - Candidate multi = popcount(core_success) > 1.
- Output register, one-cycle latency: a hit in cycle t gives result_valid=1 at t+1.
- Handshake:
  - Transfer occurs on result_valid & result_ready.
  - result_valid, result_nonce and result_multi hold stable until transfer.
  - result_ready may be high while result_valid=0; no effect.
- Boundary cases:
  - Hit + transfer in the same cycle: load the new hit, result_valid stays 1, no bubble.
  - Hit while full with no transfer: drop the hit, keep the old result, set overflow.
  - Transfer with no hit: result_valid goes to 0.
  - Newblock iteration: flush the pending result (result_valid=0) and clear overflow, before the hit logic. A hit in that same iteration is loaded as count 0.
  - Newblock flush and transfer in the same cycle: treat as a flush. The transfer completes; the consumer sees the old data.
- Reset mid-operation: all state returns to reset values immediately. The first iteration after reset uses count 0, whether or not newblock is set.

Optional Feature:
- Macro: NONCE_RESULT_HIT_COUNT_EN.
- Defined: adds output hit_count (16 bits), incremented once per hit iteration (including dropped hits). Cleared on newblock iteration and reset. Saturates at 0xFFFF.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package miner_result_pkg:
  - nonce_t (logic [31:0]).
  - Localparam NONCE_W=32.
  - Function idx_width(n) returning max(1,$clog2(n)).
- Sub-module lowest_set_encoder #(N): combinational; outputs index of the lowest set bit, an any flag and a multi flag. Instantiated once for core_success.

Test Plan:
- Single hit: NUM_CORES=4. Newblock iteration, then 2 plain iterations; 3rd iteration (count 2) core 3 success, prefix 3, result_ready=0 -> next cycle result_valid=1, result_nonce=0x0000000B, result_multi=0. Holds until ready; drops 1 cycle after ready=1.
- Multi hit: count 5, cores 1 and 2 succeed -> result_nonce=0x00000015, result_multi=1.
- Overflow and back-to-back:
  - Result pending, ready=0, hit at count 7 -> nonce unchanged, overflow=1.
  - Same scenario with ready=1 -> nonce=0x0000001C+prefix, result_valid stays 1.
- Newblock flush: pending result plus overflow, then newblock iteration with core 0 success -> overflow=0, result_nonce=0x00000000, result_valid=1.
- Wrap: preload counter near max via 2^30 iterations (or force) -> exhausted 1-cycle pulse after count 0x3FFFFFFF iteration; next nonce uses count 0.
- Lockstep and reset: core_valid=4'b0111 -> lockstep_err=1, persists. Async rst low mid-hold -> all outputs 0 without a clock edge.
